// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite mover: direction codes, FSM states, screen defaults.
// Helper functions turn a direction code into per-axis step signs.
package sprite_pkg;

    localparam int SCR_W_DEF = 320;
    localparam int SCR_H_DEF = 240;

    typedef enum logic [2:0] {
        DIR_XN   = 3'b000,
        DIR_YP   = 3'b001,
        DIR_YN   = 3'b010,
        DIR_XP   = 3'b011,
        DIR_XPYP = 3'b100,
        DIR_XNYP = 3'b101,
        DIR_XPYN = 3'b110,
        DIR_XNYN = 3'b111
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CALC   = 3'd1,
        ST_QUERY  = 3'd2,
        ST_ERASE  = 3'd3,
        ST_UPDATE = 3'd4,
        ST_DRAW   = 3'd5
    } state_t;

    // Returns {decrement, increment} for the x axis.
    function automatic logic [1:0] step_x(input logic [2:0] d);
        case (d)
            DIR_XN, DIR_XNYP, DIR_XNYN: step_x = 2'b10;
            DIR_XP, DIR_XPYP, DIR_XPYN: step_x = 2'b01;
            default:                    step_x = 2'b00;
        endcase
    endfunction

    // Returns {decrement, increment} for the y axis.
    function automatic logic [1:0] step_y(input logic [2:0] d);
        case (d)
            DIR_YN, DIR_XPYN, DIR_XNYN: step_y = 2'b10;
            DIR_YP, DIR_XPYP, DIR_XNYP: step_y = 2'b01;
            default:                    step_y = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: tick is high for one cycle every TICK_DIV cycles, first at count TICK_DIV-1.
// No backpressure; the pulse is combinational from the counter register.
module tick_gen #(
    parameter int TICK_DIV = 6250000
) (
    input  logic clock,
    input  logic resetn,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign tick = (r_cnt == LAST);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sprite_mover_n.sv
// Moves a sprite one step per tick via query/erase/update/draw handshakes; accepted move >= 5 cycles.
// Each handshake state holds its request level until the peer answers; lift and hide act only in IDLE.
module sprite_mover_n
    import sprite_pkg::*;
#(
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int SCR_W    = SCR_W_DEF,
    parameter int SCR_H    = SCR_H_DEF,
    parameter int STEP     = 1,
    parameter int TICK_DIV = 6250000,
    parameter int X0       = 95,
    parameter int Y0       = 221
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           move,
    input  logic [2:0]     dir,
    output logic           chk_req,
    output logic [X_W-1:0] chk_x,
    output logic [Y_W-1:0] chk_y,
    input  logic           chk_ack,
    input  logic           chk_ok,
    input  logic           chk_tele,
    input  logic [X_W-1:0] tele_x,
    input  logic [Y_W-1:0] tele_y,
    output logic           draw_bg,
    input  logic           done_bg,
    output logic           draw_char,
    input  logic           done_char,
    input  logic           lift,
    input  logic [Y_W-1:0] lift_dy,
    input  logic           hide,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           busy
);

    localparam logic [X_W:0] STEP_X  = (X_W+1)'(STEP);
    localparam logic [Y_W:0] STEP_Y  = (Y_W+1)'(STEP);
    localparam logic [X_W:0] LIMIT_X = (X_W+1)'(SCR_W);
    localparam logic [Y_W:0] LIMIT_Y = (Y_W+1)'(SCR_H);

    state_t         r_state, w_next;
    logic           w_tick;
    logic           w_accept;
    logic [X_W-1:0] r_x, r_tx;
    logic [Y_W-1:0] r_y, r_ty;
    logic [2:0]     r_dir;
    logic           r_lift_pend;
    logic [Y_W-1:0] r_lift_dy;
    logic [Y_W-1:0] w_lift_y;
    logic [1:0]     w_sx, w_sy;
    logic [X_W:0]   w_nx;
    logic [Y_W:0]   w_ny;
    logic           w_inb;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock  (clock),
        .resetn (resetn),
        .tick   (w_tick)
    );

    assign w_accept = (r_state == ST_IDLE) && move && w_tick && !hide;

    // Candidate is one bit wider so stepping below zero wraps to a huge value and fails the upper bound.
    assign w_sx = step_x(r_dir);
    assign w_sy = step_y(r_dir);
    assign w_nx = w_sx[1] ? ({1'b0, r_x} - STEP_X) : w_sx[0] ? ({1'b0, r_x} + STEP_X) : {1'b0, r_x};
    assign w_ny = w_sy[1] ? ({1'b0, r_y} - STEP_Y) : w_sy[0] ? ({1'b0, r_y} + STEP_Y) : {1'b0, r_y};
    assign w_inb = (w_nx != '0) && (w_nx < LIMIT_X) && (w_ny != '0) && (w_ny < LIMIT_Y);

    assign w_lift_y = (r_y > r_lift_dy) ? (r_y - r_lift_dy) : '0;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        chk_req   = 1'b0;
        draw_bg   = 1'b0;
        draw_char = 1'b0;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next = ST_CALC;
            ST_CALC:   w_next = w_inb ? ST_QUERY : ST_IDLE;
            ST_QUERY: begin
                chk_req = 1'b1;
                if (chk_ack) w_next = chk_ok ? ST_ERASE : ST_IDLE;
            end
            ST_ERASE: begin
                draw_bg = 1'b1;
                if (done_bg) w_next = ST_UPDATE;
            end
            ST_UPDATE: w_next = ST_DRAW;
            ST_DRAW: begin
                draw_char = 1'b1;
                if (done_char) w_next = ST_IDLE;
            end
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_x         <= X_W'(X0);
            r_y         <= Y_W'(Y0);
            r_tx        <= X_W'(X0);
            r_ty        <= Y_W'(Y0);
            r_dir       <= '0;
            r_lift_pend <= 1'b0;
            r_lift_dy   <= '0;
        end else begin
            if (w_accept) r_dir <= dir;

            if (r_state == ST_CALC) begin
                r_tx <= w_nx[X_W-1:0];
                r_ty <= w_ny[Y_W-1:0];
            end else if (r_state == ST_QUERY && chk_ack && chk_ok && chk_tele) begin
                r_tx <= tele_x;
                r_ty <= tele_y;
            end

            if (r_state == ST_UPDATE) begin
                r_x <= r_tx;
                r_y <= r_ty;
            end else if (r_state == ST_IDLE && hide) begin
                r_x <= X_W'(SCR_W);
                r_y <= Y_W'(SCR_H);
            end else if (r_state == ST_IDLE && r_lift_pend && !w_accept) begin
                r_y <= w_lift_y;
            end

            // Hidden sprites keep the lift pending so it lands once the sprite reappears.
            if (r_lift_pend) begin
                if (r_state == ST_IDLE && !w_accept && !hide) r_lift_pend <= 1'b0;
            end else if (lift) begin
                r_lift_pend <= 1'b1;
                r_lift_dy   <= lift_dy;
            end
        end
    end

    assign chk_x = r_tx;
    assign chk_y = r_ty;
    assign x     = r_x;
    assign y     = r_y;
    assign busy  = (r_state != ST_IDLE);

endmodule
